operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/calc_pkg.sv | 14 +
 rtl/btn_conditioner.sv | 61 ++++++
 rtl/operand_loader.sv | 109 ++++++++++
 tb/tb_operand_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the operand loading front end: default widths,
// default debounce length and the loader FSM state encodings.
package calc_pkg;

  localparam int DEFAULT_DATA_W          = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    S_WAIT_A = 2'b00,
    S_WAIT_B = 2'b01,
    S_READY  = 2'b10
  } state_t;

endpackage : calc_pkg

// File: rtl/btn_conditioner.sv
// Turns a raw, bouncing, asynchronous push button into a single-cycle pulse:
// 2-flop synchronizer -> counter debouncer -> rising-edge detector.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the debounced level
  // on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q   <= 1'b0;
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      prev_q <= db_q;
    end
  end

  // One-cycle pulse on each debounced press; held buttons give one pulse.
  assign pulse_o = db_q & ~prev_q;

endmodule : btn_conditioner

// File: rtl/operand_loader.sv
// Loads two operands from the switches with a single load button, in the
// order A then B; a clear button restarts the sequence and zeroes both.
module operand_loader
  import calc_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_load,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] a_data,
  output logic              a_en,
  output logic [DATA_W-1:0] b_data,
  output logic              b_en,
  output logic              operands_valid,
  output logic [1:0]        state_o
);

  logic load_p, clear_p;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              a_en_q, a_en_d;
  logic              b_en_q, b_en_d;
  logic              valid_q, valid_d;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_cond (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_load),
    .pulse_o (load_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_cond (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_clear),
    .pulse_o (clear_p)
  );

  // Next state and next outputs; clear takes priority over load.
  always_comb begin
    state_d  = state_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    a_en_d   = 1'b0;
    b_en_d   = 1'b0;
    if (clear_p) begin
      state_d  = S_WAIT_A;
      a_data_d = '0;
      b_data_d = '0;
    end else begin
      case (state_q)
        S_WAIT_A: begin
          if (load_p) begin
            state_d  = S_WAIT_B;
            a_en_d   = 1'b1;
            a_data_d = sw;
          end
        end
        S_WAIT_B: begin
          if (load_p) begin
            state_d  = S_READY;
            b_en_d   = 1'b1;
            b_data_d = sw;
          end
        end
        S_READY: begin
          state_d = S_READY;
        end
        default: begin
          state_d = S_WAIT_A;
        end
      endcase
    end
    valid_d = (state_d == S_READY);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT_A;
      a_data_q <= '0;
      b_data_q <= '0;
      a_en_q   <= 1'b0;
      b_en_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_en_q   <= a_en_d;
      b_en_q   <= b_en_d;
      valid_q  <= valid_d;
    end
  end

  assign a_data         = a_data_q;
  assign b_data         = b_data_q;
  assign a_en           = a_en_q;
  assign b_en           = b_en_q;
  assign operands_valid = valid_q;
  assign state_o        = state_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: stimulus pushes each expected write
// (operand, data, cycle) into a queue; a monitor pops it when an enable fires.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sw;
  logic       btn_load, btn_clear;
  logic [4:0] a_data, b_data;
  logic       a_en, b_en, operands_valid;
  logic [1:0] state_o;

  typedef struct {
    bit         is_b;
    logic [4:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  operand_loader dut (
    .clk            (clk),
    .reset          (reset),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clear      (btn_clear),
    .a_data         (a_data),
    .a_en           (a_en),
    .b_data         (b_data),
    .b_en           (b_en),
    .operands_valid (operands_valid),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input bit is_b, input logic [4:0] data, input int at);
    exp_t e;
    e.is_b = is_b;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic check_regs(input string tag, input int st, input int ad,
                            input int bd, input int vld);
    chk({tag, ".state_o"}, int'(state_o), st);
    chk({tag, ".a_data"}, int'(a_data), ad);
    chk({tag, ".b_data"}, int'(b_data), bd);
    chk({tag, ".operands_valid"}, int'(operands_valid), vld);
  endtask

  // Monitor: every enable must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!done && (a_en || b_en)) begin
      if (a_en && b_en) chk("both_enables", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_enable", int'({a_en, b_en}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("en_is_b", int'(b_en), int'(e.is_b));
        chk("en_data", e.is_b ? int'(b_data) : int'(a_data), int'(e.data));
        chk("en_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset = 1'b1; sw = '0; btn_load = 1'b0; btn_clear = 1'b0;
    tick(3);
    check_regs("reset", 0, 0, 0, 0);
    chk("reset.a_en", int'(a_en), 0);
    chk("reset.b_en", int'(b_en), 0);
    reset = 1'b0;
    tick(2);

    // Hold load with sw=9: A written after edge 7.
    sw = 5'd9;
    btn_load = 1'b1;
    expect_write(1'b0, 5'd9, cyc + 7);
    tick(12);
    check_regs("loadA", 1, 9, 0, 0);

    // Release, sw=22, press again: B written.
    btn_load = 1'b0;
    tick(10);
    sw = 5'd22;
    btn_load = 1'b1;
    expect_write(1'b1, 5'd22, cyc + 7);
    tick(12);
    check_regs("loadB", 2, 9, 22, 1);

    // Third press in S_READY: no enable, nothing changes.
    btn_load = 1'b0;
    tick(10);
    sw = 5'd7;
    btn_load = 1'b1;
    tick(12);
    check_regs("third", 2, 9, 22, 1);
    btn_load = 1'b0;
    tick(10);

    // Clear and load pressed together in S_READY: clear wins.
    btn_load = 1'b1;
    btn_clear = 1'b1;
    tick(12);
    check_regs("clr_ld", 0, 0, 0, 0);
    btn_load = 1'b0;
    btn_clear = 1'b0;
    tick(10);

    // Short glitches of 1..3 cycles, repeated: no pulse.
    sw = 5'd17;
    for (int len = 1; len <= 3; len++) begin
      for (int r = 0; r < 2; r++) begin
        btn_load = 1'b1;
        tick(len);
        btn_load = 1'b0;
        tick(5);
      end
    end
    tick(5);
    check_regs("glitch", 0, 0, 0, 0);

    // Load A (sw=3) to reach S_WAIT_B.
    sw = 5'd3;
    btn_load = 1'b1;
    expect_write(1'b0, 5'd3, cyc + 7);
    tick(12);
    check_regs("loadA2", 1, 3, 0, 0);
    btn_load = 1'b0;
    tick(10);

    // Reset 3 cycles into a debounce while in S_WAIT_B: outputs clear at once.
    sw = 5'd12;
    btn_load = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    check_regs("async_rst", 0, 0, 0, 0);
    tick(2);
    reset = 1'b0;
    expect_write(1'b0, 5'd12, cyc + 7);
    tick(12);
    check_regs("after_rst", 1, 12, 0, 0);

    btn_load = 1'b0;
    tick(3);
    chk("pending_expectations", exp_q.size(), 0);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_operand_loader
